// File: rtl/fifo_rd_adapt_pkg.sv
// Shared types and sizing for the FIFO read-side stream adapter.
// Optional statistics counters are enabled with FIFO_RD_ADAPT_STATS_EN.
package fifo_rd_adapt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int RD_LATENCY = 1;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int LVL_W      = CNT_W + 1;

    // Beats owned by the adapter after this cycle: buffered + returning - leaving.
    function automatic logic [LVL_W-1:0] credit_level(
        input logic [CNT_W-1:0] cnt,
        input logic             inflight,
        input logic             pop
    );
        return {1'b0, cnt} + LVL_W'(inflight) - LVL_W'(pop);
    endfunction

endpackage

// File: rtl/fifo_rd_adapt_skid.sv
// Two-entry skid buffer; entry 0 is the registered stream head.
// Push and pop may coincide; clear drops all buffered beats.
module fifo_rd_adapt_skid
    import fifo_rd_adapt_pkg::*;
#(
    parameter int DAT_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic [DAT_WIDTH-1:0] din,
    output logic [CNT_W-1:0]     cnt,
    output logic [DAT_WIDTH-1:0] head
);

    logic [DAT_WIDTH-1:0] ent0;
    logic [DAT_WIDTH-1:0] ent1;
    logic [CNT_W-1:0]     cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == CNT_W'(0)) begin
                        ent0 <= din;
                    end else begin
                        ent1 <= din;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                2'b01: begin
                    ent0  <= ent1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                // pop implies cnt >= 1, so only the 1 and 2 cases exist
                2'b11: begin
                    if (cnt_q == CNT_W'(SKID_DEPTH)) begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end else begin
                        ent0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign head = ent0;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Pops a dual-clock FIFO envelope and presents a registered valid/ready stream.
// FIFO_RD_ADAPT_STATS_EN adds beat_cnt and stall_cnt outputs.
module fifo_rd_stream_adapter
    import fifo_rd_adapt_pkg::*;
#(
    parameter int DAT_WIDTH = 26,
    parameter int PTR_WIDTH = 9
) (
    input  logic                 rd_clk,
    input  logic                 rd_reset_n,
    input  logic                 en,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 rd_op,
    input  logic [DAT_WIDTH-1:0] rd_data,
    input  logic                 rd_empty,
    input  logic [PTR_WIDTH:0]   rd_entry_used,
    input  logic                 rd_empty_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DAT_WIDTH-1:0] out_data,
`ifdef FIFO_RD_ADAPT_STATS_EN
    output logic [15:0]          beat_cnt,
    output logic [15:0]          stall_cnt,
`endif
    output logic                 err_sticky
);

    state_t           state_q;
    state_t           state_d;
    logic             inflight_q;
    logic [CNT_W-1:0] cnt;
    logic [LVL_W-1:0] level;
    logic             pop;
    logic             push;
    logic             clear;

    assign pop   = out_valid & out_ready;
    assign level = credit_level(cnt, inflight_q, pop);

    assign rd_op = (state_q == RUN) & ~rd_empty
                 & (level < LVL_W'(SKID_DEPTH));

    // Returns landing during or after a flush request are already stale.
    assign push  = inflight_q & (state_q != FLUSH);
    assign clear = flush | (state_q == FLUSH);

    assign flush_done = (state_q == FLUSH) & ~inflight_q;
    assign out_valid  = (cnt != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (!inflight_q) begin
                    state_d = en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_op;
            err_sticky <= err_sticky | rd_empty_err;
        end
    end

    fifo_rd_adapt_skid #(
        .DAT_WIDTH (DAT_WIDTH)
    ) u_skid (
        .clk   (rd_clk),
        .rst_n (rd_reset_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (rd_data),
        .cnt   (cnt),
        .head  (out_data)
    );

`ifdef FIFO_RD_ADAPT_STATS_EN
    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    logic occ_unused;
    assign occ_unused = ^rd_entry_used;
`else
    // Occupancy is only of interest to statistics logic.
    logic occ_unused;
    assign occ_unused = ^rd_entry_used;
`endif

endmodule
